// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage conditional-branch predictor. A gshare (or
//               bimodal) indexed table of 2-bit saturating counters, with a
//               private F->D->E shadow pipeline so that each resolved branch
//               trains exactly the entry that produced its prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int GHR_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  F_pc,
  input  logic [4:0]       F_opcode,
  input  logic             stall,
  input  logic             flush,
  input  logic             E_taken,
  output logic             predict,
  output logic             E_pred,
  output logic             E_br_valid,
  output logic             E_mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int         c_ENTRIES   = 1 << IDX_W;
  localparam logic [4:0] c_OP_BRANCH = 5'b11000;
  localparam logic [1:0] c_CNT_WNT   = 2'b01;
  localparam logic [1:0] c_CNT_ST    = 2'b11;
  localparam logic [1:0] c_CNT_SNT   = 2'b00;

  // Pattern history table and non-speculative global history
  logic [1:0]       r_pht [c_ENTRIES];
  logic [IDX_W-1:0] r_ghr;

  // Shadow pipeline: decode and execute copies of {vld, idx, pred}
  logic             r_d_vld;
  logic [IDX_W-1:0] r_d_idx;
  logic             r_d_pred;
  logic             r_e_vld;
  logic [IDX_W-1:0] r_e_idx;
  logic             r_e_pred;

  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  logic [IDX_W-1:0] w_hist;
  logic [IDX_W-1:0] w_f_idx;
  logic             w_f_is_br;
  logic             w_e_pred;
  logic             w_mispredict;

  // Only the word-offset bits above the byte offset feed the index
  logic             w_unused_pc;
  assign w_unused_pc = ^{F_pc[PC_W-1:IDX_W+2], F_pc[1:0]};

  // History folding: gshare XORs the GHR in, bimodal uses the PC alone
  generate
    if (GHR_EN != 0) begin : g_gshare
      assign w_hist = r_ghr;
    end else begin : g_bimodal
      logic w_unused_ghr;
      assign w_unused_ghr = ^r_ghr;
      assign w_hist       = '0;
    end
  endgenerate

  // F-stage lookup; reads the table as it stood before this edge's update
  assign w_f_idx   = F_pc[IDX_W+1:2] ^ w_hist;
  assign w_f_is_br = (F_opcode == c_OP_BRANCH);
  assign predict   = w_f_is_br & r_pht[w_f_idx][1];

  // E-stage view presented to the controller
  assign w_e_pred     = r_e_pred & r_e_vld;
  assign w_mispredict = r_e_vld & (E_taken != w_e_pred);

  assign E_br_valid   = r_e_vld;
  assign E_pred       = w_e_pred;
  assign E_mispredict = w_mispredict;
  assign br_cnt       = r_br_cnt;
  assign mis_cnt      = r_mis_cnt;

  // Shadow pipeline advance: flush beats stall; a stalled D keeps its lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_vld  <= 1'b0;
      r_d_idx  <= '0;
      r_d_pred <= 1'b0;
      r_e_vld  <= 1'b0;
      r_e_idx  <= '0;
      r_e_pred <= 1'b0;
    end else if (flush) begin
      r_d_vld <= 1'b0;
      r_e_vld <= 1'b0;
    end else if (stall) begin
      r_e_vld <= 1'b0;
    end else begin
      r_d_vld  <= w_f_is_br;
      r_d_idx  <= w_f_idx;
      r_d_pred <= predict;
      r_e_vld  <= r_d_vld;
      r_e_idx  <= r_d_idx;
      r_e_pred <= r_d_pred;
    end
  end

  // Training: bulk reset, otherwise update from the resolving E branch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_pht[i] <= c_CNT_WNT;
      end
      r_ghr     <= '0;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (r_e_vld) begin
      if (E_taken) begin
        if (r_pht[r_e_idx] != c_CNT_ST) begin
          r_pht[r_e_idx] <= r_pht[r_e_idx] + 2'd1;
        end
      end else begin
        if (r_pht[r_e_idx] != c_CNT_SNT) begin
          r_pht[r_e_idx] <= r_pht[r_e_idx] - 2'd1;
        end
      end
      r_ghr <= {r_ghr[IDX_W-2:0], E_taken};
      if (r_br_cnt != '1) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_mispredict && (r_mis_cnt != '1)) begin
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed bench for branch_predictor. A bimodal instance with
//               narrow counters carries the scoreboarded directed vectors; a
//               gshare instance shares the stimulus for the correlation run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam logic [4:0] c_OP_BR  = 5'b11000;
  localparam logic [4:0] c_OP_ALU = 5'b01100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] F_pc;
  logic [4:0]  F_opcode;
  logic        stall;
  logic        flush;
  logic        E_taken;

  logic        predict_b, e_pred_b, e_brv_b, e_mis_b;
  logic [3:0]  br_cnt_b, mis_cnt_b;
  logic        predict_g, e_pred_g, e_brv_g, e_mis_g;
  logic [15:0] br_cnt_g, mis_cnt_g;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  sb_q [$];
  logic [1:0]  exp_v;
  logic        prev_tk;
  logic        late_win = 1'b0;
  int          late_mis_g = 0;
  int          late_mis_b = 0;

  branch_predictor #(.PC_W(32), .IDX_W(4), .GHR_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .F_pc(F_pc), .F_opcode(F_opcode),
    .stall(stall), .flush(flush), .E_taken(E_taken),
    .predict(predict_b), .E_pred(e_pred_b), .E_br_valid(e_brv_b),
    .E_mispredict(e_mis_b), .br_cnt(br_cnt_b), .mis_cnt(mis_cnt_b)
  );

  branch_predictor #(.PC_W(32), .IDX_W(4), .GHR_EN(1), .CNT_W(16)) dut_g (
    .clk(clk), .rst(rst), .F_pc(F_pc), .F_opcode(F_opcode),
    .stall(stall), .flush(flush), .E_taken(E_taken),
    .predict(predict_g), .E_pred(e_pred_g), .E_br_valid(e_brv_g),
    .E_mispredict(e_mis_g), .br_cnt(br_cnt_g), .mis_cnt(mis_cnt_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] pc, input logic stl,
                       input logic fl, input logic tk);
    F_opcode = br ? c_OP_BR : c_OP_ALU;
    F_pc     = pc;
    stall    = stl;
    flush    = fl;
    E_taken  = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One branch in F, then a bubble; the previous branch resolves in slot A
  task automatic pass(input logic [31:0] pc, input logic outcome,
                      input logic exp_pred, input logic exp_mis);
    drive(1'b1, pc, 1'b0, 1'b0, prev_tk);
    sb_q.push_back({exp_pred, exp_mis});
    @(negedge clk);
    check("predict", {31'd0, predict_b}, {31'd0, exp_pred});
    tick();
    prev_tk = outcome;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, 1'b0, 1'b0, prev_tk);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    prev_tk = 1'b0;
  endtask

  // Combinational lookup with flush held so nothing enters the pipeline
  task automatic peek(input logic br, input logic [31:0] pc, input logic exp);
    drive(br, pc, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("peek predict", {31'd0, predict_b}, {31'd0, exp});
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    check("scoreboard drained", sb_q.size(), 0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    prev_tk = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check({tag, " predict"},      {31'd0, predict_b}, 0);
    check({tag, " E_pred"},       {31'd0, e_pred_b},  0);
    check({tag, " E_br_valid"},   {31'd0, e_brv_b},   0);
    check({tag, " E_mispredict"}, {31'd0, e_mis_b},   0);
    check({tag, " br_cnt"},       {28'd0, br_cnt_b},  0);
    check({tag, " mis_cnt"},      {28'd0, mis_cnt_b}, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every valid E branch must match the next expectation
  always @(negedge clk) begin
    if (rst !== 1'b1 && e_brv_b === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected E branch", 32'd1, 32'd0);
      end else begin
        exp_v = sb_q.pop_front();
        check("E_pred", {31'd0, e_pred_b}, {31'd0, exp_v[1]});
        check("E_mispredict", {31'd0, e_mis_b}, {31'd0, exp_v[0]});
      end
    end
    if (late_win && rst !== 1'b1) begin
      if (e_mis_g === 1'b1) late_mis_g++;
      if (e_mis_b === 1'b1) late_mis_b++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    prev_tk = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // Warm-up and saturation at idx 0
    reset_dut();
    check_idle("reset");
    pass(32'h40, 1'b1, 1'b0, 1'b1);
    pass(32'h40, 1'b1, 1'b0, 1'b1);
    pass(32'h40, 1'b1, 1'b1, 1'b0);
    pass(32'h40, 1'b1, 1'b1, 1'b0);
    pass(32'h40, 1'b0, 1'b1, 1'b1);
    drain();
    check("br_cnt after 5", {28'd0, br_cnt_b}, 5);
    check("mis_cnt after 5", {28'd0, mis_cnt_b}, 3);
    peek(1'b1, 32'h40, 1'b1);
    peek(1'b0, 32'h40, 1'b0);
    pass(32'h40, 1'b0, 1'b1, 1'b1);
    drain();
    peek(1'b1, 32'h40, 1'b0);
    check("br_cnt after 6", {28'd0, br_cnt_b}, 6);
    check("mis_cnt after 6", {28'd0, mis_cnt_b}, 4);

    // Load-use stall with the branch held in D for two cycles
    reset_dut();
    drive(1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(2'b01);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("stall E_br_valid", {31'd0, e_brv_b}, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post-stall bubble", {31'd0, e_brv_b}, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("no second E", {31'd0, e_brv_b}, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("stall br_cnt", {28'd0, br_cnt_b}, 1);
    check("stall mis_cnt", {28'd0, mis_cnt_b}, 1);
    peek(1'b1, 32'h48, 1'b1);

    // Flush raised by the E branch kills the younger branch in D
    reset_dut();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(2'b01);
    tick();
    drive(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("flushed branch in E", {31'd0, e_brv_b}, 0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("flush br_cnt", {28'd0, br_cnt_b}, 1);
    check("flush mis_cnt", {28'd0, mis_cnt_b}, 1);
    peek(1'b1, 32'h40, 1'b1);
    peek(1'b1, 32'h4C, 1'b0);

    // Alternating outcomes at one idx: every resolve mispredicts, counters saturate
    reset_dut();
    for (int k = 0; k < 17; k++) begin
      pass(32'h40, (k % 2) == 0, (k % 2) != 0, 1'b1);
      drain();
    end
    check("mis_cnt saturated", {28'd0, mis_cnt_b}, 15);
    check("br_cnt saturated", {28'd0, br_cnt_b}, 15);

    // Reset while branches occupy D and E
    check("queue empty before mid reset", sb_q.size(), 0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    check_idle("mid reset");
    for (int i = 0; i < 16; i++) begin
      peek(1'b1, 32'h40 + 32'(4 * i), 1'b0);
    end
    prev_tk = 1'b0;
    pass(32'h40, 1'b1, 1'b0, 1'b1);
    drain();
    peek(1'b1, 32'h40, 1'b1);

    // Correlated pair: gshare learns it, bimodal never does
    reset_dut();
    for (int it = 0; it < 64; it++) begin
      if (it == 32) late_win = 1'b1;
      pass(32'h40, (it % 2) == 0, (it % 2) != 0, 1'b1);
      drain();
      pass(32'h44, (it % 2) == 0, (it % 2) != 0, 1'b1);
      drain();
    end
    late_win = 1'b0;
    check("gshare late mispredicts", late_mis_g, 0);
    check("bimodal late mispredicts", late_mis_b, 64);
    check("gshare br_cnt", {16'd0, br_cnt_g}, 128);
    check("bimodal mis_cnt held", {28'd0, mis_cnt_b}, 15);
    check("final scoreboard drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
